// File: rtl/led_fifo_pixel_reader_if.sv
// Bundle for the FIFO read port and the downstream pixel stream.
// The master modport is the reader side; slave is the FIFO/consumer side.
interface led_fifo_pixel_reader_if #(
    parameter int unsigned DATA_W = 12
);
    logic              fifo_re;
    logic [DATA_W-1:0] fifo_do;
    logic              fifo_empty;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_sol;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output fifo_re,
        input  fifo_do,
        input  fifo_empty,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output pix_sof,
        output pix_sol,
        output pix_eol,
        output pix_eof
    );

    modport slave (
        input  fifo_re,
        output fifo_do,
        output fifo_empty,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  pix_sof,
        input  pix_sol,
        input  pix_eol,
        input  pix_eof
    );
endinterface

// File: rtl/led_fifo_pixel_reader.sv
// Read-side LED pixel FIFO consumer: credit-based pops into a 2-entry skid buffer, pixel stream
// with frame/line markers. Define LED_PIX_UNDERRUN_CNT_EN to add the mid-line underrun counter.
module led_fifo_pixel_reader #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned LINE_PIX    = 64,
    parameter int unsigned FRAME_LINES = 32
) (
    input  logic                   clkr,
    input  logic                   rst_n,
    input  logic                   flush,
    led_fifo_pixel_reader_if.master bus
`ifdef LED_PIX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);

    localparam int unsigned ColW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam int unsigned RowW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    if (LINE_PIX < 2) begin : g_bad_line
        $error("LINE_PIX must be 2 or more");
    end
    if (FRAME_LINES < 1) begin : g_bad_frame
        $error("FRAME_LINES must be 1 or more");
    end

    logic [DATA_W-1:0] buf_q [2];
    logic              head_q;
    logic [1:0]        count_q, count_d;
    logic              inflight_q;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;

    logic              pop;
    logic              push;
    logic              tail;
    logic              col_last;
    logic              row_last;
    logic [2:0]        credit;

    // Datapath control and read issue
    always_comb begin
        pop      = (count_q != 2'd0) && bus.pix_ready;
        push     = inflight_q && !flush;
        // With a 1-bit head pointer the tail is head offset by occupancy mod 2; at occupancy 2
        // it aliases the head, which is only written when the head is popped the same cycle.
        tail     = head_q ^ count_q[0];
        credit   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        count_d  = count_q + {1'b0, push} - {1'b0, pop};

        bus.fifo_re = rst_n && !bus.fifo_empty && !flush && (credit < 3'd2);
    end

    // Position counters advance on handshake only
    always_comb begin
        col_last = (col_q == ColW'(LINE_PIX - 1));
        row_last = (row_q == RowW'(FRAME_LINES - 1));
        col_d    = col_q;
        row_d    = row_q;
        if (pop) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_comb begin
        bus.pix_valid = (count_q != 2'd0);
        bus.pix_data  = bus.pix_valid ? buf_q[head_q] : '0;
        bus.pix_sol   = bus.pix_valid && (col_q == '0);
        bus.pix_sof   = bus.pix_valid && (col_q == '0) && (row_q == '0);
        bus.pix_eol   = bus.pix_valid && col_last;
        bus.pix_eof   = bus.pix_valid && col_last && row_last;
    end

    always_ff @(posedge clkr or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else if (flush) begin
            // Returning read data is dropped along with the buffered pixels
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            if (push) begin
                buf_q[tail] <= bus.fifo_do;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q    <= count_d;
            inflight_q <= bus.fifo_re;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

`ifdef LED_PIX_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    // Starvation only counts mid-line; idling between lines is expected
    always_ff @(posedge clkr or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 16'd0;
        end else if (flush) begin
            underrun_q <= 16'd0;
        end else if (bus.pix_ready && !bus.pix_valid && (col_q != '0) &&
                     (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

    a_no_overflow: assert property (@(posedge clkr) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));
    a_count_range: assert property (@(posedge clkr) disable iff (!rst_n)
        count_q != 2'd3);

endmodule

// File: tb/tb_led_fifo_pixel_reader.sv
// Randomized bench for led_fifo_pixel_reader: two DUTs (64x32 and 4x2 geometry) share one
// stimulus and are checked against a queue-based reference of the FIFO and pixel stream.
module tb_led_fifo_pixel_reader;

    localparam int LA = 64;
    localparam int FA = 32;
    localparam int LB = 4;
    localparam int FB = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fifo_empty;
    logic [11:0] fifo_do;
    logic        pix_ready;

    led_fifo_pixel_reader_if #(.DATA_W(12)) bus_a ();
    led_fifo_pixel_reader_if #(.DATA_W(12)) bus_b ();

    assign bus_a.fifo_empty = fifo_empty;
    assign bus_a.fifo_do    = fifo_do;
    assign bus_a.pix_ready  = pix_ready;
    assign bus_b.fifo_empty = fifo_empty;
    assign bus_b.fifo_do    = fifo_do;
    assign bus_b.pix_ready  = pix_ready;

`ifdef LED_PIX_UNDERRUN_CNT_EN
    logic [15:0] uc_dut_a;
    logic [15:0] uc_dut_b;
`endif

    led_fifo_pixel_reader #(.DATA_W(12), .LINE_PIX(LA), .FRAME_LINES(FA)) dut_a (
        .clkr  (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_a)
`ifdef LED_PIX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (uc_dut_a)
`endif
    );

    led_fifo_pixel_reader #(.DATA_W(12), .LINE_PIX(LB), .FRAME_LINES(FB)) dut_b (
        .clkr  (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_b)
`ifdef LED_PIX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (uc_dut_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: source FIFO contents, word in flight, pixels awaiting handshake
    logic [11:0] src[$];
    logic [11:0] exp_q[$];
    bit          arr_v;
    logic [11:0] arr_d;
    int          k;
    int          uc_a;
    int          uc_b;
    int          seq;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_marks(input int idx, input int l, input int f, input bit v);
        int col;
        int row;
        col = idx % l;
        row = (idx / l) % f;
        return {v && col == 0 && row == 0, v && col == 0, v && col == l - 1,
                v && col == l - 1 && row == f - 1};
    endfunction

    function automatic logic [11:0] next_word();
        seq++;
        return 12'(seq);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        arr_v = 1'b0;
        k     = 0;
        uc_a  = 0;
        uc_b  = 0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_re"}, {31'd0, bus_a.fifo_re | bus_b.fifo_re}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, bus_a.pix_valid | bus_b.pix_valid}, 32'd0);
        check_val({tag, "_data"}, {20'd0, bus_a.pix_data | bus_b.pix_data}, 32'd0);
        check_val({tag, "_marks"}, {28'd0, bus_a.pix_sof, bus_a.pix_sol, bus_a.pix_eol,
                  bus_a.pix_eof | bus_b.pix_eof}, 32'd0);
`ifdef LED_PIX_UNDERRUN_CNT_EN
        check_val({tag, "_uc"}, {16'd0, uc_dut_a | uc_dut_b}, 32'd0);
`endif
    endtask

    task automatic compare();
        bit          v;
        bit          pop;
        bit          re;
        logic [11:0] d;
        int          pending;
        v       = exp_q.size() != 0;
        d       = v ? exp_q[0] : 12'd0;
        pop     = v && pix_ready;
        pending = exp_q.size() + int'(arr_v);
        re      = !fifo_empty && !flush && (pending - int'(pop) < 2);
        check_val("fifo_re_a", {31'd0, bus_a.fifo_re}, {31'd0, re});
        check_val("fifo_re_b", {31'd0, bus_b.fifo_re}, {31'd0, re});
        check_val("valid_a", {31'd0, bus_a.pix_valid}, {31'd0, v});
        check_val("valid_b", {31'd0, bus_b.pix_valid}, {31'd0, v});
        check_val("data_a", {20'd0, bus_a.pix_data}, {20'd0, d});
        check_val("data_b", {20'd0, bus_b.pix_data}, {20'd0, d});
        check_val("marks_a", {28'd0, bus_a.pix_sof, bus_a.pix_sol, bus_a.pix_eol, bus_a.pix_eof},
                  {28'd0, exp_marks(k, LA, FA, v)});
        check_val("marks_b", {28'd0, bus_b.pix_sof, bus_b.pix_sol, bus_b.pix_eol, bus_b.pix_eof},
                  {28'd0, exp_marks(k, LB, FB, v)});
`ifdef LED_PIX_UNDERRUN_CNT_EN
        check_val("underrun_a", {16'd0, uc_dut_a}, 32'(uc_a));
        check_val("underrun_b", {16'd0, uc_dut_b}, 32'(uc_b));
`endif
    endtask

    // One clock: drive at negedge, check, then advance the reference at posedge
    task automatic step(input bit rdy, input bit fl, input bit gap);
        bit re_seen;
        bit v;
        @(negedge clk);
        pix_ready  = rdy;
        flush      = fl;
        fifo_empty = (src.size() == 0) || gap;
        #1;
        compare();
        re_seen = bus_a.fifo_re;
        v       = exp_q.size() != 0;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (rdy && !v && (k % LA) != 0 && uc_a < 16'hFFFF) uc_a++;
            if (rdy && !v && (k % LB) != 0 && uc_b < 16'hFFFF) uc_b++;
            if (v && rdy) begin
                void'(exp_q.pop_front());
                k++;
            end
            if (arr_v) exp_q.push_back(arr_d);
        end
        arr_v = 1'b0;
        if (re_seen && src.size() != 0) begin
            arr_d = src.pop_front();
            arr_v = !fl;
        end
        #1;
        fifo_do = arr_v ? arr_d : 12'($urandom);
    endtask

    // Asynchronous reset asserted mid-cycle, released before the next negedge
    task automatic do_reset();
        @(negedge clk);
        pix_ready = 1'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid");
        model_clear();
        @(posedge clk);
        #1;
        fifo_do = 12'($urandom);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        seq        = 64;
        rst_n      = 1'b0;
        flush      = 1'b0;
        fifo_empty = 1'b1;
        fifo_do    = 12'd0;
        pix_ready  = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        #2;
        rst_n = 1'b1;

        // Basic stream: 0x001..0x040 at one pixel per cycle
        for (int i = 1; i <= 64; i++) src.push_back(12'(i));
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b0);

        // Backpressure with ready pattern 1,0,0,1
        for (int i = 0; i < 10; i++) src.push_back(next_word());
        for (int i = 0; i < 32; i++) step((i % 4 == 0) || (i % 4 == 3), 1'b0, 1'b0);

        // Empty boundary: 3 words, a gap, then a refill
        for (int i = 0; i < 3; i++) src.push_back(next_word());
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) src.push_back(next_word());
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Flush at col 5 with a read in flight
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) src.push_back(next_word());
        for (int i = 0; i < 40 && k != 5; i++) step(1'b1, 1'b0, 1'b0);
        check_val("reach_col5_flush", 32'(k), 32'd5);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Same via asynchronous reset
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) src.push_back(next_word());
        for (int i = 0; i < 40 && k != 5; i++) step(1'b1, 1'b0, 1'b0);
        check_val("reach_col5_reset", 32'(k), 32'd5);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        // Mid-line starvation: 3 pixels then an empty stretch, then 1 more to reach col 4
        step(1'b1, 1'b1, 1'b0);
        src.delete();
        for (int i = 0; i < 3; i++) src.push_back(next_word());
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        src.push_back(next_word());
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Randomized traffic with gaps, stalls, flushes and resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) src.push_back(next_word());
            if (src.size() < 2 && $urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 6; j++) src.push_back(next_word());
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 4) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
